// File: rtl/axis_burst_packer_if.sv
// Stream bundle around the burst packer: narrow samples in, packed words out.
// The slave modport is the packer itself; master is the surrounding logic.
interface axis_burst_packer_if #(
  parameter int IN_WIDTH = 16,
  parameter int RATIO    = 8
);
  localparam int FILL_W = $clog2(RATIO + 1);

  logic [IN_WIDTH-1:0]       s_tdata;
  logic                      s_tvalid;
  logic                      s_tready;
  logic                      s_tlast;
  logic [IN_WIDTH*RATIO-1:0] m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tlast;
  logic [FILL_W-1:0]         m_fill;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_fill
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_fill
  );
endinterface

// File: rtl/axis_burst_packer.sv
// Packs RATIO narrow samples into one full-width word; partial words leave on
// s_tlast or after FLUSH_TIMEOUT idle clocks so nothing is stranded.
module axis_burst_packer #(
  parameter int                  IN_WIDTH      = 16,
  parameter int                  RATIO         = 8,
  parameter int                  FLUSH_TIMEOUT = 256,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic               aclk,
  input  logic               reset,
  axis_burst_packer_if.slave bus,
  output logic [15:0]        flush_cnt
);
  localparam int  CW       = $clog2(RATIO);
  localparam int  FW       = $clog2(RATIO + 1);
  localparam int  TW       = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam bit  FLUSH_EN = (FLUSH_TIMEOUT > 0);
  localparam logic [TW-1:0] TMAX     = TW'(FLUSH_TIMEOUT);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  typedef logic [RATIO-1:0][IN_WIDTH-1:0] lanes_t;
  localparam lanes_t PAD_WORD = {RATIO{PAD_VALUE}};

  lanes_t          acc_q, acc_d, acc_new;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  lanes_t          m_tdata_q, m_tdata_d;
  logic            m_tvalid_q, m_tvalid_d;
  logic            m_tlast_q, m_tlast_d;
  logic [FW-1:0]   m_fill_q, m_fill_d;
  logic [15:0]     flush_cnt_q, flush_cnt_d;
  logic            out_free, accept, close_word, flush;

  // Only path from m_tready to s_tready; keeps the output stage a single register.
  assign out_free     = !m_tvalid_q || bus.m_tready;
  assign bus.s_tready = out_free;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept     = bus.s_tvalid && out_free;
    close_word = accept && ((cnt_q == LAST_IDX) || bus.s_tlast);
    flush      = FLUSH_EN && (cnt_q != '0) && (timer_q == TMAX) && !accept && out_free;

    acc_new = acc_q;
    if (accept) acc_new[cnt_q] = bus.s_tdata;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_fill_d    = m_fill_q;
    flush_cnt_d = flush_cnt_q;

    if (m_tvalid_q && bus.m_tready) m_tvalid_d = 1'b0;

    if (close_word) begin
      m_tdata_d  = acc_new;
      m_fill_d   = FW'(cnt_q) + FW'(1);
      m_tlast_d  = bus.s_tlast;
      m_tvalid_d = 1'b1;
      acc_d      = PAD_WORD;
      cnt_d      = '0;
    end else if (accept) begin
      acc_d = acc_new;
      cnt_d = cnt_q + CW'(1);
    end else if (flush) begin
      // Unfilled lanes already hold PAD_VALUE, so the accumulator goes out as-is.
      m_tdata_d  = acc_q;
      m_fill_d   = FW'(cnt_q);
      m_tlast_d  = 1'b0;
      m_tvalid_d = 1'b1;
      acc_d      = PAD_WORD;
      cnt_d      = '0;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    timer_d = timer_q;
    if (accept || (cnt_q == '0) || flush) timer_d = '0;
    else if (timer_q < TMAX)              timer_d = timer_q + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge aclk) begin
    if (reset) begin
      // NOTE: the accumulator is reset too, because unfilled lanes must read
      // PAD_VALUE when a partial word is emitted.
      acc_q       <= PAD_WORD;
      cnt_q       <= '0;
      timer_q     <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_fill_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_fill_q    <= m_fill_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_fill   = m_fill_q;
  assign flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_axis_burst_packer.sv
// Directed bench for axis_burst_packer: cycle vector tables with expected
// words, plus hand-written backpressure, timeout, collision and reset sequences.
module tb_axis_burst_packer;
  localparam int          IN_W  = 16;
  localparam int          RATIO = 8;
  localparam int          FT    = 16;
  localparam logic [15:0] PAD   = 16'hEEEE;

  logic        aclk = 1'b0;
  logic        reset;
  logic [15:0] flush_cnt;

  axis_burst_packer_if #(.IN_WIDTH(IN_W), .RATIO(RATIO)) bus ();

  axis_burst_packer #(
    .IN_WIDTH(IN_W), .RATIO(RATIO), .FLUSH_TIMEOUT(FT), .PAD_VALUE(PAD)
  ) dut (
    .aclk(aclk), .reset(reset), .bus(bus), .flush_cnt(flush_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        rdy;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   fill;
    logic         last;
  } word_t;

  vec_t  vecs[$];
  word_t exp_words[$];
  word_t got[$];
  int    checks = 0;
  int    errors = 0;
  logic  acc_in, rdy_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, record the pre-edge handshakes, then advance past the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic rdy);
    word_t w;
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.m_tready = rdy;
    #1;
    rdy_seen = bus.s_tready;
    acc_in   = bus.s_tvalid && bus.s_tready;
    if (bus.m_tvalid && bus.m_tready) begin
      w.data = bus.m_tdata;
      w.fill = bus.m_fill;
      w.last = bus.m_tlast;
      got.push_back(w);
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic void add_vec(logic v, logic [15:0] d, logic l, logic rdy, logic er);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.rdy = rdy; x.exp_rdy = er;
    vecs.push_back(x);
  endfunction

  function automatic void add_word(logic [127:0] data, logic [3:0] fill, logic last);
    word_t w;
    w.data = data; w.fill = fill; w.last = last;
    exp_words.push_back(w);
  endfunction

  task automatic compare_words(input string tag);
    check($sformatf("%s word count", tag), 128'(got.size()), 128'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s w%0d data", tag, i), got[i].data, exp_words[i].data);
        check($sformatf("%s w%0d fill", tag, i), 128'(got[i].fill), 128'(exp_words[i].fill));
        check($sformatf("%s w%0d last", tag, i), 128'(got[i].last), 128'(exp_words[i].last));
      end
    end
  endtask

  task automatic run_vecs(input string tag);
    got.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].rdy);
      check($sformatf("%s s_tready[%0d]", tag, i), 128'(rdy_seen), 128'(vecs[i].exp_rdy));
    end
    compare_words(tag);
    vecs.delete();
    exp_words.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           idx, k;
    logic         stable_ok, have_snap, quiet_ok;
    logic [127:0] snap;

    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tlast = 1'b0; bus.m_tready = 1'b0;
    reset = 1'b1;
    step(0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 0);
    reset = 1'b0;
    check("reset m_tvalid", 128'(bus.m_tvalid), 128'(0));
    check("reset m_tdata", bus.m_tdata, 128'h0);
    check("reset m_tlast", 128'(bus.m_tlast), 128'(0));
    check("reset m_fill", 128'(bus.m_fill), 128'(0));
    check("reset flush_cnt", 128'(flush_cnt), 128'(0));

    // Two full words back-to-back, no stall.
    for (int i = 0; i < 16; i++) add_vec(1, 16'(i + 1), 0, 1, 1);
    add_vec(0, 16'h0, 0, 1, 1);
    add_word(128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8, 1'b0);
    add_word(128'h0010_000f_000e_000d_000c_000b_000a_0009, 4'd8, 1'b0);
    run_vecs("full");

    // Partial word closed by s_tlast; next sample opens a fresh word in lane 0.
    add_vec(1, 16'h00A1, 0, 1, 1);
    add_vec(1, 16'h00A2, 0, 1, 1);
    add_vec(1, 16'h00A3, 1, 1, 1);
    add_vec(1, 16'h00B1, 1, 1, 1);
    add_vec(0, 16'h0, 0, 1, 1);
    add_word(128'hEEEE_EEEE_EEEE_EEEE_EEEE_00A3_00A2_00A1, 4'd3, 1'b1);
    add_word(128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_00B1, 4'd1, 1'b1);
    run_vecs("tlast");

    // Backpressure: 50 stalled clocks with 20 samples on offer.
    got.delete();
    idx = 0; stable_ok = 1'b1; have_snap = 1'b0; snap = '0;
    for (int c = 0; c < 50; c++) begin
      step(idx < 20, 16'h0101 + 16'(idx), idx == 19, 0);
      if (acc_in) idx++;
      if (bus.m_tvalid) begin
        if (!have_snap) begin
          snap = bus.m_tdata;
          have_snap = 1'b1;
        end else if (bus.m_tdata !== snap) begin
          stable_ok = 1'b0;
        end
      end
    end
    check("bp accepted during stall", 128'(idx), 128'(8));
    check("bp s_tready low", 128'(rdy_seen), 128'(0));
    check("bp m_tdata stable", 128'(stable_ok), 128'(1));
    check("bp stalled fill", 128'(bus.m_fill), 128'(8));
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      step(idx < 20, 16'h0101 + 16'(idx), idx == 19, 1);
      if (acc_in) idx++;
    end
    check("bp all accepted", 128'(idx), 128'(20));
    add_word(128'h0108_0107_0106_0105_0104_0103_0102_0101, 4'd8, 1'b0);
    add_word(128'h0110_010f_010e_010d_010c_010b_010a_0109, 4'd8, 1'b0);
    add_word(128'hEEEE_EEEE_EEEE_EEEE_0114_0113_0112_0111, 4'd4, 1'b1);
    compare_words("bp");
    exp_words.delete();

    // Timeout flush: output must appear 17 clocks after the last accepted beat.
    for (int i = 0; i < 5; i++) step(1, 16'h0201 + 16'(i), 0, 1);
    k = 0;
    while (k < 40 && !bus.m_tvalid) begin
      step(0, 16'h0, 0, 1);
      k++;
    end
    check("to latency", 128'(k), 128'(17));
    check("to data", bus.m_tdata, 128'hEEEE_EEEE_EEEE_0205_0204_0203_0202_0201);
    check("to fill", 128'(bus.m_fill), 128'(5));
    check("to last", 128'(bus.m_tlast), 128'(0));
    check("to flush_cnt", 128'(flush_cnt), 128'(1));
    step(0, 16'h0, 0, 1);
    check("to drained", 128'(bus.m_tvalid), 128'(0));

    // Collision: a sample arriving as the timer saturates pre-empts the flush.
    step(1, 16'h0301, 0, 1);
    step(1, 16'h0302, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 16'h0, 0, 1);
    check("col before", 128'(bus.m_tvalid), 128'(0));
    step(1, 16'h0303, 0, 1);
    check("col accepted", 128'(acc_in), 128'(1));
    check("col no flush", 128'(bus.m_tvalid), 128'(0));
    check("col flush_cnt held", 128'(flush_cnt), 128'(1));
    for (int i = 0; i < 16; i++) step(0, 16'h0, 0, 1);
    check("col timer restarted", 128'(bus.m_tvalid), 128'(0));
    step(0, 16'h0, 0, 1);
    check("col flush valid", 128'(bus.m_tvalid), 128'(1));
    check("col flush data", bus.m_tdata, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_0303_0302_0301);
    check("col flush fill", 128'(bus.m_fill), 128'(3));
    check("col flush_cnt", 128'(flush_cnt), 128'(2));
    step(0, 16'h0, 0, 1);

    // Reset mid-word discards the partial word and the flush counter.
    for (int i = 0; i < 4; i++) step(1, 16'h0401 + 16'(i), 0, 1);
    reset = 1'b1;
    step(0, 16'h0, 0, 1);
    reset = 1'b0;
    check("rst m_tvalid", 128'(bus.m_tvalid), 128'(0));
    check("rst flush_cnt", 128'(flush_cnt), 128'(0));
    quiet_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(0, 16'h0, 0, 1);
      if (bus.m_tvalid) quiet_ok = 1'b0;
    end
    check("rst nothing emitted", 128'(quiet_ok), 128'(1));
    for (int i = 0; i < 8; i++) add_vec(1, 16'h0501 + 16'(i), 0, 1, 1);
    add_vec(0, 16'h0, 0, 1, 1);
    add_word(128'h0508_0507_0506_0505_0504_0503_0502_0501, 4'd8, 1'b0);
    run_vecs("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_burst_packer.md
Name: axis_burst_packer

Overview:
- Upstream feeder for the MIG-based AXIS FIFO.
- Packs narrow AXI-Stream samples into one full-width FIFO word (IN_WIDTH*RATIO bits) so every write to external DDR3 carries a full UI data word.
- Flushes partial words on input tlast, or after a programmable idle timeout, so data is never stranded in the packer.
- Output drives the FIFO's in_tdata/in_tvalid/in_tready directly, in the MIG ui_clk domain.

Parameters:
- IN_WIDTH, 16, input sample width in bits.
- RATIO, 8, samples per output word (output width = IN_WIDTH*RATIO = 128 by default); must be ≥2.
- FLUSH_TIMEOUT, 256, idle cycles with a partial word before a forced flush; 0 disables the timeout.
- PAD_VALUE, 0, IN_WIDTH-bit value written into unfilled lanes of a partial word.

Ports:
- aclk  in  1  clock (MIG ui_clk)
- reset  in  1  synchronous reset, active-high
- s_tdata  in  IN_WIDTH  input sample
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  end of packet; closes the current word
- m_tdata  out  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  word closed by s_tlast
- m_fill  out  $clog2(RATIO+1)  number of valid lanes in m_tdata (1..RATIO)
- flush_cnt  out  16  saturating count of timeout-forced flushes

Behaviour:
- Reset is synchronous, active-high: one clock with reset=1 clears all state.
  - Outputs after reset: m_tvalid=0, m_tdata=0, m_tlast=0, m_fill=0, flush_cnt=0.
  - Internal state after reset: lane counter=0, accumulator=PAD_VALUE in every lane, idle timer=0.
- Reset mid-word: the partial accumulator contents and any pending output word are discarded; nothing is emitted.
- Structure:
  - Accumulator register with lane counter cnt (0..RATIO-1).
  - One output register (m_*).
- s_tready = !m_tvalid || m_tready. This is combinational; it is the only m_tready→s_tready path.
- Input beat accepted (s_tvalid && s_tready):
  - Sample is written to lane cnt; lane 0 is the first sample (LSBs).
  - If cnt==RATIO-1 or s_tlast=1, the word closes on the same clock:
    - Output register loads {accumulator with new lane, remaining lanes=PAD_VALUE}.
    - m_fill=cnt+1, m_tlast=s_tlast, m_tvalid=1.
    - Accumulator resets to PAD_VALUE lanes; cnt returns to 0.
  - Otherwise cnt increments.
  - Latency: the closing beat's sample appears on m_tdata one clock after acceptance.
- Output handshake:
  - m_tvalid && m_tready clears m_tvalid, unless a new word loads on the same edge; then m_tvalid stays 1 with the new contents.
  - m_tdata, m_fill and m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Idle timer:
  - Resets to 0 on any accepted beat, or whenever cnt==0.
  - Otherwise increments by 1 per clock, saturating at FLUSH_TIMEOUT.
- Timeout flush:
  - Fires when FLUSH_TIMEOUT>0, cnt>0, timer==FLUSH_TIMEOUT, no input beat accepted this clock, and the output register is free (!m_tvalid || m_tready).
  - Loads a partial word: m_fill=cnt, m_tlast=0.
  - Clears cnt and the timer; flush_cnt increments, saturating at 16'hFFFF.
  - If the output register is not free, the flush waits; the timer stays saturated.
  - Priority: an accepted input beat always pre-empts a timeout flush on the same clock.
- No word is ever emitted with m_fill=0. No sample is ever dropped or duplicated.
- Sustained throughput with m_tready=1: 1 sample/clock in; 1 word every RATIO clocks out.

Test Plan:
- Full words, no stall: samples 16'h0001..16'h0010 back-to-back, m_tready=1, s_tlast=0 → exactly 2 words:
  - word 0: lanes 0..7 = 0001..0008, m_fill=8, m_tlast=0.
  - word 1: lanes 0..7 = 0009..0010, m_fill=8, m_tlast=0.
  - s_tready stays high throughout.
- tlast partial word: 3 samples A1,A2,A3 with s_tlast on A3 → one word:
  - lanes 0..2 = A1,A2,A3; lanes 3..7 = PAD_VALUE.
  - m_fill=3, m_tlast=1.
  - Next sample lands in lane 0 of a new word.
- Backpressure: m_tready=0 for 50 clocks while 20 samples are offered →
  - At most 8 samples accepted (the closing beat loads the output register), then s_tready=0.
  - m_tdata stays stable.
  - After m_tready=1: all 20 samples emerge in order across 3 words (8, 8, and 4 samples).
- Timeout flush: FLUSH_TIMEOUT=16; 5 samples then s_tvalid=0 → one word with m_fill=5, m_tlast=0, and flush_cnt=1, asserted 17 clocks after the last accepted beat.
- Flush/input collision: a sample arrives in the exact clock the timer saturates → the sample is accepted into lane cnt, no flush occurs, and the timer restarts.
- Reset mid-word: 4 samples accepted, then reset=1 for 1 clock → no output word is produced, and the next 8 samples form one clean word starting at lane 0.
